ctrl_word_queue: RTL and testbench

//  Parametrised FIFO of decoded instruction entries (rv32i_control_word + PC + raw

---
 rtl/ctrl_word_queue_pkg.sv | 43 ++++
 rtl/ctrl_word_queue.sv | 111 +++++++++++
 tb/tb_ctrl_word_queue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_word_queue_pkg.sv
// rtl/ctrl_word_queue_pkg.sv - decoded-instruction types shared by decode, execute and the queue
//
// Purpose: RV32I control word, raw instruction word and the decode entry that is
// buffered between decode and execute. CTRL_W / ENTRY_W give flat widths for ports.
// Ports: none (package).
package ctrl_word_queue_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
  } rv32i_control_word;

  // pc is fixed at 32 bits; a wider XLEN needs this field widened.
  typedef struct packed {
    rv32i_control_word ctrl;
    logic [31:0]       pc;
    rv32i_word         instr;
  } rv32i_decode_entry;

  localparam int CTRL_W  = $bits(rv32i_control_word);
  localparam int ENTRY_W = $bits(rv32i_decode_entry);

endpackage

// File: rtl/ctrl_word_queue.sv
// rtl/ctrl_word_queue.sv - FIFO of decoded instruction entries between decode and execute
//
// Purpose: circular buffer of DEPTH decode entries with valid/ready on both sides,
// flush for redirects, occupancy count and optional empty-queue bypass.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard all held entries
//   enq_valid/enq_ready      enqueue handshake; enq_ctrl/enq_pc/enq_instr payload
//   deq_valid/deq_ready      dequeue handshake; deq_ctrl/deq_pc/deq_instr head payload
//   count                    entries held (a bypassed entry is never counted)
module ctrl_word_queue
  import ctrl_word_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int XLEN   = 32,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [CTRL_W-1:0]          enq_ctrl,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [31:0]                enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [CTRL_W-1:0]          deq_ctrl,
  output logic [XLEN-1:0]            deq_pc,
  output logic [31:0]                deq_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rv32i_decode_entry mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  rv32i_decode_entry enq_entry, deq_entry;
  logic empty, bypass_avail, enq_fire, deq_fire, pass_through, wr_en, rd_en;

  always_comb begin
    enq_entry       = '0;
    enq_entry.ctrl  = rv32i_control_word'(enq_ctrl);
    enq_entry.pc    = 32'(enq_pc);
    enq_entry.instr = enq_instr;

    empty        = (count_q == '0);
    bypass_avail = (BYPASS != 0) && empty && enq_valid;
    // enq_ready comes only from registered state: no ready path through deq_ready.
    enq_ready    = (count_q < CNT_W'(DEPTH));
    deq_valid    = !flush && (!empty || bypass_avail);

    // When empty the only way deq_valid can be high is the bypass, so the head
    // comes straight from the enqueue port.
    if (!deq_valid)  deq_entry = '0;
    else if (empty)  deq_entry = enq_entry;
    else             deq_entry = mem_q[head_q];

    enq_fire     = enq_valid && enq_ready;
    deq_fire     = deq_valid && deq_ready;
    pass_through = deq_fire && empty;
    wr_en        = enq_fire && !pass_through && !flush;
    rd_en        = deq_fire && !empty;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = tail_q + PTR_W'(1);
      if (rd_en) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign deq_ctrl  = deq_entry.ctrl;
  assign deq_pc    = XLEN'(deq_entry.pc);
  assign deq_instr = deq_entry.instr;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[tail_q] <= enq_entry;
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
    !(enq_fire && count_q == CNT_W'(DEPTH)));
  a_no_deq_when_invalid: assert property (@(posedge clk) disable iff (rst)
    !(rd_en && !deq_valid));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ctrl_word_queue.sv
// tb/tb_ctrl_word_queue.sv - self-checking bench for ctrl_word_queue (BYPASS=0 and BYPASS=1)
module tb_ctrl_word_queue;
  import ctrl_word_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = CTRL_W + 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, enq_valid, deq_ready;
  logic [CTRL_W-1:0] enq_ctrl;
  logic [31:0]       enq_pc, enq_instr;

  logic              enq_ready0, deq_valid0, enq_ready1, deq_valid1;
  logic [CTRL_W-1:0] deq_ctrl0, deq_ctrl1;
  logic [31:0]       deq_pc0, deq_pc1, deq_instr0, deq_instr1;
  logic [2:0]        count0, count1;

  ctrl_word_queue #(.DEPTH(DEPTH), .XLEN(32), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready0),
    .enq_ctrl(enq_ctrl), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid0), .deq_ready(deq_ready),
    .deq_ctrl(deq_ctrl0), .deq_pc(deq_pc0), .deq_instr(deq_instr0),
    .count(count0)
  );

  ctrl_word_queue #(.DEPTH(DEPTH), .XLEN(32), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready1),
    .enq_ctrl(enq_ctrl), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .deq_valid(deq_valid1), .deq_ready(deq_ready),
    .deq_ctrl(deq_ctrl1), .deq_pc(deq_pc1), .deq_instr(deq_instr1),
    .count(count1)
  );

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a plain queue per instance. Expected outputs follow from its size
  // and head; the update pops what the consumer takes and pushes what is accepted.
  task automatic check_model(input int which);
    int           n;
    bit           e_rdy, e_dv, took_bypass;
    logic [W-1:0] head, e_data, a_data, cur;
    logic [63:0]  a_cnt;
    bit           a_rdy, a_dv;
    cur  = {enq_ctrl, enq_pc, enq_instr};
    n    = (which == 1) ? mq1.size() : mq0.size();
    head = '0;
    if (n != 0) head = (which == 1) ? mq1[0] : mq0[0];
    e_rdy  = (n < DEPTH);
    e_dv   = !flush && (n != 0 || (which == 1 && enq_valid));
    e_data = !e_dv ? '0 : (n != 0 ? head : cur);
    a_rdy  = (which == 1) ? enq_ready1 : enq_ready0;
    a_dv   = (which == 1) ? deq_valid1 : deq_valid0;
    a_cnt  = (which == 1) ? 64'(count1) : 64'(count0);
    a_data = (which == 1) ? {deq_ctrl1, deq_pc1, deq_instr1} : {deq_ctrl0, deq_pc0, deq_instr0};
    if (armed) begin
      chk($sformatf("b%0d_count", which), a_cnt, 64'(n));
      chk($sformatf("b%0d_enq_ready", which), 64'(a_rdy), 64'(e_rdy));
      chk($sformatf("b%0d_deq_valid", which), 64'(a_dv), 64'(e_dv));
      chk($sformatf("b%0d_deq_ctrl", which), 64'(a_data[W-1 -: CTRL_W]), 64'(e_data[W-1 -: CTRL_W]));
      chk($sformatf("b%0d_deq_pc", which), 64'(a_data[63:32]), 64'(e_data[63:32]));
      chk($sformatf("b%0d_deq_instr", which), 64'(a_data[31:0]), 64'(e_data[31:0]));
    end
    if (rst || flush) begin
      if (which == 1) mq1.delete(); else mq0.delete();
    end else begin
      took_bypass = 0;
      if (e_dv && deq_ready) begin
        if (n != 0) begin
          if (which == 1) void'(mq1.pop_front()); else void'(mq0.pop_front());
        end else begin
          took_bypass = 1;
        end
      end
      if (enq_valid && e_rdy && !took_bypass) begin
        if (which == 1) mq1.push_back(cur); else mq0.push_back(cur);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic ev, input logic dr,
                       input logic [31:0] pc, input logic [CTRL_W-1:0] c, input logic [31:0] ins);
    @(negedge clk);
    rst = r; flush = f; enq_valid = ev; deq_ready = dr;
    enq_pc = pc; enq_ctrl = c; enq_instr = ins;
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic cycle_pc(input logic r, input logic f, input logic ev, input logic dr,
                          input logic [31:0] pc);
    cycle(r, f, ev, dr, pc, CTRL_W'(pc * 3 + 7), ~pc);
  endtask

  typedef struct {
    logic        ev, dr;
    logic [31:0] pc;
    int          cnt;
    logic        er, dv;
    logic [31:0] dpc;
  } vec_t;

  vec_t tbl[11];
  rv32i_control_word jal_ctrl;

  initial begin
    rst = 1; flush = 0; enq_valid = 0; deq_ready = 0;
    enq_pc = '0; enq_ctrl = '0; enq_instr = '0;

    // Fill to full with deq_ready low, refuse a 5th, then drain in order (BYPASS=0).
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 0, 1'b1, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 32'h04, 1, 1'b1, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 32'h08, 2, 1'b1, 1'b1, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 32'h0C, 3, 1'b1, 1'b1, 32'h00};
    tbl[5]  = '{1'b1, 1'b0, 32'h10, 4, 1'b0, 1'b1, 32'h00};
    tbl[6]  = '{1'b0, 1'b1, 32'h00, 4, 1'b0, 1'b1, 32'h00};
    tbl[7]  = '{1'b0, 1'b1, 32'h00, 3, 1'b1, 1'b1, 32'h04};
    tbl[8]  = '{1'b0, 1'b1, 32'h00, 2, 1'b1, 1'b1, 32'h08};
    tbl[9]  = '{1'b0, 1'b1, 32'h00, 1, 1'b1, 1'b1, 32'h0C};
    tbl[10] = '{1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 32'h00};

    cycle_pc(1, 0, 0, 0, 0);
    armed = 1;
    cycle_pc(1, 0, 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      cycle_pc(0, 0, tbl[i].ev, tbl[i].dr, tbl[i].pc);
      chk($sformatf("vec%0d_count", i), 64'(count0), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d_enq_ready", i), 64'(enq_ready0), 64'(tbl[i].er));
      chk($sformatf("vec%0d_deq_valid", i), 64'(deq_valid0), 64'(tbl[i].dv));
      chk($sformatf("vec%0d_deq_pc", i), 64'(deq_pc0), 64'(tbl[i].dpc));
    end

    // Steady enqueue+dequeue at count=2 long enough for pointers to wrap.
    cycle_pc(0, 0, 1, 0, 32'h200);
    cycle_pc(0, 0, 1, 0, 32'h204);
    for (int k = 0; k < 10; k++) begin
      cycle_pc(0, 0, 1, 1, 32'h208 + 32'(4 * k));
      chk($sformatf("stream%0d_count", k), 64'(count0), 64'd2);
      chk($sformatf("stream%0d_pc", k), 64'(deq_pc0), 64'(32'h200 + 32'(4 * k)));
    end
    cycle_pc(0, 0, 0, 1, 0);
    cycle_pc(0, 0, 0, 1, 0);

    // Flush at count=3 with a concurrent enqueue that must vanish.
    cycle_pc(0, 0, 1, 0, 32'h300);
    cycle_pc(0, 0, 1, 0, 32'h304);
    cycle_pc(0, 0, 1, 0, 32'h308);
    cycle_pc(0, 1, 1, 1, 32'h40);
    chk("flush_forces_invalid", 64'(deq_valid0), 64'd0);
    chk("flush_enq_ready", 64'(enq_ready0), 64'd1);
    cycle_pc(0, 0, 0, 1, 0);
    chk("post_flush_count", 64'(count0), 64'd0);
    chk("post_flush_valid", 64'(deq_valid0), 64'd0);
    cycle_pc(0, 0, 0, 1, 0);
    cycle_pc(0, 0, 0, 1, 0);

    // Bypass on an empty queue: same-cycle pass-through, then held when stalled.
    jal_ctrl = '0;
    jal_ctrl.opcode = op_jal;
    jal_ctrl.rd = 5'd1;
    cycle(0, 0, 1, 1, 32'h100, CTRL_W'(jal_ctrl), 32'h0000_00EF);
    chk("bypass_valid", 64'(deq_valid1), 64'd1);
    chk("bypass_pc", 64'(deq_pc1), 64'h100);
    chk("bypass_ctrl", 64'(deq_ctrl1), 64'(CTRL_W'(jal_ctrl)));
    chk("bypass_count", 64'(count1), 64'd0);
    chk("nobypass_valid", 64'(deq_valid0), 64'd0);
    cycle_pc(0, 0, 0, 0, 0);
    chk("bypass_not_stored", 64'(count1), 64'd0);
    chk("bypass_gone", 64'(deq_valid1), 64'd0);
    cycle_pc(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 32'h100, CTRL_W'(jal_ctrl), 32'h0000_00EF);
    chk("bypass_stall_pc", 64'(deq_pc1), 64'h100);
    for (int k = 0; k < 2; k++) begin
      cycle_pc(0, 0, 0, 0, 0);
      chk($sformatf("stall%0d_count", k), 64'(count1), 64'd1);
      chk($sformatf("stall%0d_pc", k), 64'(deq_pc1), 64'h100);
    end
    cycle_pc(0, 0, 0, 1, 0);

    // Reset mid-operation with an enqueue pending.
    cycle_pc(0, 0, 1, 0, 32'h600);
    cycle_pc(0, 0, 1, 0, 32'h604);
    cycle_pc(1, 0, 1, 0, 32'h608);
    cycle_pc(0, 0, 0, 1, 0);
    chk("rst_count0", 64'(count0), 64'd0);
    chk("rst_valid0", 64'(deq_valid0), 64'd0);
    chk("rst_count1", 64'(count1), 64'd0);
    cycle_pc(0, 0, 0, 1, 0);

    // Randomised traffic against the queue model.
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0),
            $urandom, CTRL_W'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
